obufds_serializer: RTL
======================

// Module: obufds_serializer
// PURPOSE
//  Parallel-to-serial transmit stage that drives the single-ended I input of a
//  differential output buffer (LVPECL/LVDS OBUFDS family). Accepts words over a
//  valid/ready handshake and shifts them out one bit per CLK, with a
//  programmable idle gap between words. It also produces TX_EN for the
//  buffer's tristate control.
// PARAMETERS
//  WIDTH       8   bits per word (2..32)
//  MSB_FIRST   1   1: DIN[WIDTH-1] sent first; 0: DIN[0] sent first
//  GAP_CYCLES  1   idle-level cycles inserted after each word (0..15)
//  IDLE_LEVEL  0   SDO level when not shifting (0 or 1)
// PORTS
//  CLK        in   1      single clock; all state updates on rising edge
//  RST        in   1      synchronous reset, active-high
//  DIN        in   WIDTH  parallel word to send
//  DIN_VALID  in   1      DIN holds a word
//  DIN_READY  out  1      block accepts DIN this cycle
//  SDO        out  1      registered serial data -> OBUFDS I
//  TX_EN      out  1      registered; high while data bits are on SDO
//  BUSY       out  1      state != IDLE
//  DONE       out  1      one-cycle pulse, coincident with last data bit on SDO
// BEHAVIOUR
//  - One clock CLK. Reset is synchronous and active-high on RST. RST overrides
//    all other inputs, including mid-word: the word is dropped, with no
//    partial completion.
//  - Reset values: state=IDLE, SDO=IDLE_LEVEL, TX_EN=0, BUSY=0, DONE=0.
//    DIN_READY=0 while RST=1.
//  - States: IDLE, SHIFT, GAP.
//  - IDLE:
//    - DIN_READY=1.
//    - DIN_VALID=1 at edge k: capture DIN into shift reg, bit_cnt=WIDTH-1, go
//      to SHIFT.
//  - Latency: first bit appears on SDO in cycle k+1.
//  - SHIFT:
//    - Each cycle SDO = current bit and TX_EN=1; shift register and bit_cnt
//      advance one bit per CLK.
//    - When bit_cnt==0: DONE=1.
//    - Next state: GAP if GAP_CYCLES>0, else IDLE.
//  - Back-to-back with GAP_CYCLES=0: DIN_READY=1 during the last-bit cycle.
//    A handshake in that cycle loads the next word; its first bit follows the
//    last bit with no bubble (state stays SHIFT).
//  - GAP:
//    - SDO=IDLE_LEVEL, TX_EN=0 for GAP_CYCLES cycles.
//    - DIN_READY=1 in the final gap cycle. A handshake there goes directly to
//      SHIFT, so the word occupies exactly WIDTH+GAP_CYCLES cycles.
//  - DIN_READY is combinational from state/counters only. It never depends on
//    DIN_VALID.
//  - DIN is sampled only on a handshake edge; it is ignored otherwise.
//  - Throughput: one word per WIDTH+GAP_CYCLES cycles when DIN_VALID is held
//    high.
//  - Counter widths: bit_cnt=$clog2(WIDTH); gap_cnt=4 bits.
//  - BUSY is high in SHIFT and GAP. It drops the cycle after the final
//    SHIFT/GAP cycle, unless a new word was accepted.
// TESTING
//  1 Reset: RST=1 for 3 cycles with DIN_VALID=1 -> SDO=IDLE_LEVEL, TX_EN=0,
//    DIN_READY=0, BUSY=0. First cycle after release: DIN_READY=1.
//  2 Single word: WIDTH=8, MSB_FIRST=1, DIN=8'hA5 accepted at edge k ->
//    SDO=1,0,1,0,0,1,0,1 on cycles k+1..k+8; DONE high only at k+8;
//    TX_EN=1 for exactly 8 cycles.
//  3 LSB order: MSB_FIRST=0, DIN=8'h01 -> SDO=1 then seven 0s.
//  4 Streaming, GAP_CYCLES=0: DIN_VALID held high with 8'hFF then 8'h00 ->
//    16 contiguous TX_EN cycles, SDO eight 1s then eight 0s, no idle bubble.
//  5 Gap timing: GAP_CYCLES=3, two words streamed -> exactly 3 cycles of
//    SDO=IDLE_LEVEL and TX_EN=0 between last and first bits; words start
//    11 cycles apart.
//  6 Reset mid-word: RST asserted at bit 4 of 8'hF0 -> SDO=IDLE_LEVEL and
//    state IDLE next cycle; no DONE pulse; the next word is sent intact.

Source files
------------

// File: rtl/obufds_serializer.sv
// Parallel-to-serial transmit stage feeding the I input of an OBUFDS-style buffer.
// Words arrive on a valid/ready handshake and leave one bit per clock, with an optional idle gap.
module obufds_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SDO,
  output logic             TX_EN,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned CntW     = $clog2(WIDTH);
  localparam bit          NoGap    = (GAP_CYCLES == 0);
  localparam logic [3:0]  GapInit  = 4'(NoGap ? 0 : GAP_CYCLES - 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]      gap_cnt_q, gap_cnt_d;
  logic            sdo_q, sdo_d;
  logic            tx_en_q, tx_en_d;
  logic            last_bit;
  logic            accept;

  assign last_bit = (state_q == StShift) && (bit_cnt_q == '0);

  // Ready only at word boundaries so the next word follows without a bubble.
  assign DIN_READY = !RST && ((state_q == StIdle) ||
                              (last_bit && NoGap) ||
                              ((state_q == StGap) && (gap_cnt_q == '0)));
  assign accept    = DIN_VALID && DIN_READY;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sdo_d     = IDLE_LEVEL;
    tx_en_d   = 1'b0;

    unique case (state_q)
      StShift: begin
        if (!last_bit) begin
          bit_cnt_d = bit_cnt_q - CntW'(1);
          sdo_d     = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
          shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
          tx_en_d   = 1'b1;
        end else if (!NoGap) begin
          state_d   = StGap;
          gap_cnt_d = GapInit;
        end else begin
          state_d = StIdle;
        end
      end
      StGap: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // First bit goes straight to the output register; the rest wait in shift_q.
    if (accept) begin
      state_d   = StShift;
      bit_cnt_d = CntInit;
      sdo_d     = MSB_FIRST ? DIN[WIDTH-1] : DIN[0];
      shift_d   = MSB_FIRST ? (DIN << 1) : (DIN >> 1);
      tx_en_d   = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sdo_q     <= IDLE_LEVEL;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      sdo_q     <= sdo_d;
      tx_en_q   <= tx_en_d;
    end
  end

  assign SDO   = sdo_q;
  assign TX_EN = tx_en_q;
  assign BUSY  = (state_q != StIdle);
  assign DONE  = last_bit;

endmodule
